pio_out_pulse: RTL and testbench
================================

Name: pio_out_pulse

Overview:
- Avalon-MM write-side parallel output port; the write/drive counterpart to the read-only key input PIOs on the lab62soc bus.
- Holds a software-written output word for LEDs/strobes, with atomic bit set and bit clear registers.
- A hardware one-shot timer ORs a mask onto the output for a programmed number of clocks.
- Sits on the Nios II data bus; readdata is registered with 1-cycle read latency.

Parameters:
- WIDTH, 8, output port width (1..32)
- RESET_VALUE, 0, data register value after reset
- PULSE_CW, 16, pulse counter width (1..32)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- address  in  3  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  registered read data
- out_port  out  WIDTH  driven output
- pulse_busy  out  1  one-shot active
- irq  out  1  present only with PIO_OUT_PULSE_IRQ_EN

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high; the port is named reset.
- Write strobe: wr = chipselect & ~write_n. Writes take effect at the clock edge.
- Register map, reads:
  - addr 0: data[WIDTH-1:0], R/W.
  - addr 1: pulse_mask[WIDTH-1:0], R/W.
  - addr 2: pulse_len[PULSE_CW-1:0], R/W; a write also triggers the pulse.
  - addr 3: status. bit0 = busy. bit1 = done flag (with macro only, else 0). bits[31:2+] unused = 0.
  - addr 4 (outset): W only; data |= writedata. Reads 0.
  - addr 5 (outclear): W only; data &= ~writedata. Reads 0.
  - addr 6, 7: reserved; read 0, writes ignored.
- Unused upper bits read 0. writedata bits above WIDTH/PULSE_CW are ignored.
- readdata:
  - Registered every clock from the address mux, regardless of chipselect. This gives 1-cycle read latency.
  - A read in the same cycle as a write returns the pre-write value.
- Pulse counter cnt[PULSE_CW-1:0], busy = (cnt != 0):
  - Write addr 2 with N != 0: cnt <= N. busy is high for exactly N clocks, starting the cycle after the write.
  - Write addr 2 with N == 0: cnt <= 0. This aborts any active pulse the next cycle, and done is not set.
  - Retrigger while busy: cnt reloads to N. No gap is produced.
  - Otherwise, when busy: cnt decrements by 1.
  - Write and natural terminal count in the same cycle: the write wins.
- Output:
  - out_port = data | (busy ? pulse_mask : 0). It is combinational from registers, so it changes the cycle after a write.
  - pulse_busy = busy.
- Writing pulse_mask while busy changes out_port immediately, on the next cycle.
- Reset values:
  - data = RESET_VALUE; pulse_mask = 0; pulse_len = 0; cnt = 0.
  - readdata = 0; out_port = RESET_VALUE; pulse_busy = 0; irq = 0.
- Reset asserted mid-pulse: the pulse is killed immediately (asynchronous), and out_port = RESET_VALUE.

Optional Feature:
- Macro: PIO_OUT_PULSE_IRQ_EN.
- Defined:
  - Adds a sticky done flag, set the cycle cnt transitions 1->0 by natural count.
  - Adds irqmask at addr 7 bit0 (R/W); irq = done & irqmask.
  - Any write to addr 3 clears done. If the clear coincides with a new completion, set wins.
  - Status bit1 reads done.
- Not defined: no irq port, no addr 7 storage, and status bit1 reads 0.

Test Plan:
- Reset with RESET_VALUE=8'hA5 -> out_port=8'hA5, readdata=0, pulse_busy=0. Read addr 0 -> 32'h000000A5 one cycle after the address is presented.
- Write data=8'h0F, then outset 8'hF0, then outclear 8'h03 -> out_port sequence 0F, FF, FC. Readback addr 0 = 32'h000000FC; reads of addr 4/5 = 0.
- pulse_mask=8'h80, data=0, write pulse_len=5 -> out_port=8'h80 and pulse_busy=1 for exactly 5 cycles, then 8'h00.
- Pulse len 10, retrigger with 3 at cycle 6 -> busy stays continuously high and ends 3 cycles after the retrigger (9 busy cycles total). Writing len 0 mid-pulse -> busy drops next cycle.
- Assert reset at cycle 2 of a 100-cycle pulse -> out_port returns to RESET_VALUE and busy=0 immediately. After release, busy stays 0 until a new trigger.
- With PIO_OUT_PULSE_IRQ_EN, irqmask=1, len=4 -> irq rises on the cycle cnt reaches 0 and stays high. Write addr 3 -> irq=0. An aborted pulse (len 0) -> irq stays 0.

Source files
------------

// File: rtl/pio_out_pulse.sv
// pio_out_pulse: Avalon-MM write-side parallel output port.
// Holds a software-written output word with atomic bit set/clear registers.
// A one-shot hardware timer ORs pulse_mask onto the output for pulse_len clocks.
// readdata is registered, giving one-cycle read latency.
//
// Optional feature, enabled by defining PIO_OUT_PULSE_IRQ_EN:
//   - a sticky done flag, set when the pulse counter runs out naturally;
//   - irqmask at address 7;
//   - the irq output.
//
// Register map (word addresses):
//   0 data, 1 pulse_mask, 2 pulse_len (write triggers), 3 status,
//   4 outset (W), 5 outclear (W), 6 reserved, 7 irqmask / reserved.
module pio_out_pulse #(
    parameter int unsigned WIDTH       = 8,
    parameter logic [31:0] RESET_VALUE = 32'd0,
    parameter int unsigned PULSE_CW    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [WIDTH-1:0]  out_port,
    output logic              pulse_busy
`ifdef PIO_OUT_PULSE_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_MASK    = 3'd1;
    localparam logic [2:0] ADDR_LEN     = 3'd2;
    localparam logic [2:0] ADDR_STATUS  = 3'd3;
    localparam logic [2:0] ADDR_SET     = 3'd4;
    localparam logic [2:0] ADDR_CLR     = 3'd5;
    localparam logic [2:0] ADDR_IRQMASK = 3'd7;

    localparam logic [PULSE_CW-1:0] CNT_ZERO = {PULSE_CW{1'b0}};
    localparam logic [PULSE_CW-1:0] CNT_ONE  = PULSE_CW'(1);

    logic                wr_s;
    logic                trig_s;
    logic                busy_s;
    logic [WIDTH-1:0]    data_r;
    logic [WIDTH-1:0]    data_next_s;
    logic [WIDTH-1:0]    mask_r;
    logic [PULSE_CW-1:0] len_r;
    logic [PULSE_CW-1:0] cnt_r;
    logic [PULSE_CW-1:0] cnt_next_s;
    logic [31:0]         rd_mux_s;
    logic [31:0]         readdata_r;
    logic                unused_s;

`ifdef PIO_OUT_PULSE_IRQ_EN
    logic done_r;
    logic done_next_s;
    logic irqmask_r;
`endif

    // Write data bits above the implemented register widths are dropped on purpose.
    assign unused_s = ^writedata;

    assign wr_s   = chipselect & ~write_n;
    assign trig_s = wr_s && (address == ADDR_LEN);
    assign busy_s = (cnt_r != CNT_ZERO);

    // Next value of the output data word: direct write, atomic set or atomic clear.
    always_comb begin
        data_next_s = data_r;
        if (wr_s) begin
            case (address)
                ADDR_DATA: data_next_s = writedata[WIDTH-1:0];
                ADDR_SET:  data_next_s = data_r | writedata[WIDTH-1:0];
                ADDR_CLR:  data_next_s = data_r & ~writedata[WIDTH-1:0];
                default:   data_next_s = data_r;
            endcase
        end else begin
            data_next_s = data_r;
        end
    end

    // Pulse counter next state: a write reloads (and wins over terminal count), else count down.
    always_comb begin
        cnt_next_s = cnt_r;
        if (trig_s) begin
            cnt_next_s = writedata[PULSE_CW-1:0];
        end else if (busy_s) begin
            cnt_next_s = cnt_r - CNT_ONE;
        end else begin
            cnt_next_s = cnt_r;
        end
    end

`ifdef PIO_OUT_PULSE_IRQ_EN
    // Sticky done flag: natural 1->0 count sets it, a status write clears it, set wins.
    always_comb begin
        done_next_s = done_r;
        if ((cnt_r == CNT_ONE) && !trig_s) begin
            done_next_s = 1'b1;
        end else if (wr_s && (address == ADDR_STATUS)) begin
            done_next_s = 1'b0;
        end else begin
            done_next_s = done_r;
        end
    end
`endif

    // Register state: data word, pulse mask and length, counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_r <= RESET_VALUE[WIDTH-1:0];
            mask_r <= {WIDTH{1'b0}};
            len_r  <= CNT_ZERO;
            cnt_r  <= CNT_ZERO;
        end else begin
            data_r <= data_next_s;
            cnt_r  <= cnt_next_s;
            if (wr_s && (address == ADDR_MASK)) begin
                mask_r <= writedata[WIDTH-1:0];
            end
            if (trig_s) begin
                len_r <= writedata[PULSE_CW-1:0];
            end
        end
    end

`ifdef PIO_OUT_PULSE_IRQ_EN
    // Register the done flag and the interrupt enable bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_r    <= 1'b0;
            irqmask_r <= 1'b0;
        end else begin
            done_r <= done_next_s;
            if (wr_s && (address == ADDR_IRQMASK)) begin
                irqmask_r <= writedata[0];
            end
        end
    end

    assign irq = done_r & irqmask_r;
`endif

    // Read mux: zero-extended register views, write-only and reserved addresses read 0.
    always_comb begin
        rd_mux_s = 32'd0;
        case (address)
            ADDR_DATA:   rd_mux_s[WIDTH-1:0]    = data_r;
            ADDR_MASK:   rd_mux_s[WIDTH-1:0]    = mask_r;
            ADDR_LEN:    rd_mux_s[PULSE_CW-1:0] = len_r;
            ADDR_STATUS: begin
                rd_mux_s[0] = busy_s;
`ifdef PIO_OUT_PULSE_IRQ_EN
                rd_mux_s[1] = done_r;
`endif
            end
`ifdef PIO_OUT_PULSE_IRQ_EN
            ADDR_IRQMASK: rd_mux_s[0] = irqmask_r;
`endif
            default:     rd_mux_s = 32'd0;
        endcase
    end

    // Capture the read mux every clock so reads see pre-write values with 1-cycle latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata_r <= 32'd0;
        end else begin
            readdata_r <= rd_mux_s;
        end
    end

    // Drive the output port: data word, with the mask ORed in while the one-shot runs.
    always_comb begin
        out_port = data_r;
        if (busy_s) begin
            out_port = data_r | mask_r;
        end else begin
            out_port = data_r;
        end
    end

    assign readdata   = readdata_r;
    assign pulse_busy = busy_s;

endmodule

// File: tb/tb_pio_out_pulse.sv
// Directed bench for pio_out_pulse (WIDTH=8, RESET_VALUE=8'hA5, PULSE_CW=16).
// Expected values are queued when stimulus is driven and popped when sampled.
module tb_pio_out_pulse;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        pulse_busy;
`ifdef PIO_OUT_PULSE_IRQ_EN
    logic        irq;
`endif

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    pio_out_pulse #(
        .WIDTH(8),
        .RESET_VALUE(32'h0000_00A5),
        .PULSE_CW(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .out_port(out_port),
        .pulse_busy(pulse_busy)
`ifdef PIO_OUT_PULSE_IRQ_EN
        ,
        .irq(irq)
`endif
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        step();
        chipselect = 1'b0;
    endtask

    task automatic push(input string t, input logic [31:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty: observed %h, nothing expected", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", t, obs, e);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd3;
        writedata  = 32'd0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        push("rst_out", 32'h0000_00A5);  pop_check({24'd0, out_port});
        push("rst_readdata", 32'd0);     pop_check(readdata);
        push("rst_busy", 32'd0);         pop_check({31'd0, pulse_busy});
        reset = 1'b0;
        push("rd_reset_data", 32'h0000_00A5); rd(3'd0); pop_check(readdata);

        // Data write, atomic set (upper bits ignored), atomic clear
        push("out_0f", 32'h0000_000F); wr(3'd0, 32'h0000_000F); pop_check({24'd0, out_port});
        push("out_ff", 32'h0000_00FF); wr(3'd4, 32'h1234_56F0); pop_check({24'd0, out_port});
        push("out_fc", 32'h0000_00FC); wr(3'd5, 32'h0000_0003); pop_check({24'd0, out_port});
        push("rd_data_fc", 32'h0000_00FC); rd(3'd0); pop_check(readdata);
        push("rd_outset", 32'd0);      rd(3'd4); pop_check(readdata);
        push("rd_outclear", 32'd0);    rd(3'd5); pop_check(readdata);
        wr(3'd6, 32'hFFFF_FFFF);
        push("rd_reserved6", 32'd0);   rd(3'd6); pop_check(readdata);

        // Read in the same cycle as a write returns the pre-write value
        push("rdw_old", 32'h0000_00FC);
        push("rdw_out", 32'h0000_0011);
        wr(3'd0, 32'h0000_0011);
        pop_check(readdata);
        pop_check({24'd0, out_port});
        wr(3'd0, 32'd0);

        // Pulse of length 5 with mask 8'h80
        wr(3'd1, 32'h0000_0080);
        push("rd_mask", 32'h0000_0080); rd(3'd1); pop_check(readdata);
        for (int i = 0; i < 6; i++) begin
            push("p5_out", (i < 5) ? 32'h0000_0080 : 32'd0);
            push("p5_busy", (i < 5) ? 32'd1 : 32'd0);
        end
        wr(3'd2, 32'h0000_0005);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            pop_check({24'd0, out_port});
            pop_check({31'd0, pulse_busy});
        end
        push("rd_len", 32'h0000_0005); rd(3'd2); pop_check(readdata);

        // Length 10, retriggered with 3 at cycle 6: 9 continuous busy cycles
        for (int i = 0; i < 10; i++) begin
            push("retrig_busy", (i < 9) ? 32'd1 : 32'd0);
        end
        wr(3'd2, 32'd10);
        pop_check({31'd0, pulse_busy});
        for (int i = 1; i < 6; i++) begin
            step();
            pop_check({31'd0, pulse_busy});
        end
        wr(3'd2, 32'd3);
        pop_check({31'd0, pulse_busy});
        for (int i = 7; i < 10; i++) begin
            step();
            pop_check({31'd0, pulse_busy});
        end

        // Abort with length 0
        wr(3'd2, 32'd20);
        step();
        push("abort_busy", 32'd0);  wr(3'd2, 32'd0); pop_check({31'd0, pulse_busy});
        push("abort_status", 32'd0); rd(3'd3);       pop_check(readdata);

        // Asynchronous reset mid-pulse
        wr(3'd2, 32'd100);
        step();
        push("mid_busy", 32'd1); pop_check({31'd0, pulse_busy});
        reset = 1'b1;
        #1;
        push("rst_mid_out", 32'h0000_00A5); pop_check({24'd0, out_port});
        push("rst_mid_busy", 32'd0);        pop_check({31'd0, pulse_busy});
        #2;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push("post_rst_busy", 32'd0);
            step();
            pop_check({31'd0, pulse_busy});
        end
        push("post_rst_out", 32'h0000_00A5); pop_check({24'd0, out_port});

`ifdef PIO_OUT_PULSE_IRQ_EN
        // Done flag and interrupt
        wr(3'd7, 32'd1);
        push("rd_irqmask", 32'd1); rd(3'd7); pop_check(readdata);
        for (int i = 0; i < 6; i++) begin
            push("irq_seq", (i < 4) ? 32'd0 : 32'd1);
        end
        wr(3'd2, 32'd4);
        pop_check({31'd0, irq});
        for (int i = 1; i < 6; i++) begin
            step();
            pop_check({31'd0, irq});
        end
        push("status_done", 32'd2); rd(3'd3); pop_check(readdata);
        push("irq_cleared", 32'd0); wr(3'd3, 32'd0); pop_check({31'd0, irq});
        wr(3'd2, 32'd5);
        step();
        wr(3'd2, 32'd0);
        repeat (6) step();
        push("irq_abort", 32'd0); pop_check({31'd0, irq});
`else
        // Without the option: no irqmask storage, status bit1 reads 0
        wr(3'd7, 32'd1);
        push("rd_reserved7", 32'd0); rd(3'd7); pop_check(readdata);
        wr(3'd2, 32'd2);
        step();
        step();
        push("status_no_done", 32'd0); rd(3'd3); pop_check(readdata);
`endif

        if (exp_q.size() != 0) begin
            miscompares++;
            $error("FAIL scoreboard_leftover: observed %0d unchecked entries expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
